// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath:
// opcode and memory handshake in, datapath control strobes and status out.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;

  logic       PCWrite;
  logic       Branch;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUop;
  logic [1:0] PCSource;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
           illegal, state
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUop, PCSource,
           illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset controller: one state register, control outputs
// registered from the decode of the state being entered.
module multicycle_control (
  input logic          clk,
  input logic          rst,
  multicycle_control_if.master bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IEXEC   = 4'd9,
    IWB     = 4'd10,
    JUMP    = 4'd11,
    ILLEGAL = 4'd12
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       illegal_q, illegal_d;

  logic       pc_write_q, pc_write_d;
  logic       branch_q, branch_d;
  logic       branch_ne_q, branch_ne_d;
  logic       iord_q, iord_d;
  logic       mem_read_q, mem_read_d;
  logic       mem_write_q, mem_write_d;
  logic       reg_dst_q, reg_dst_d;
  logic       memto_reg_q, memto_reg_d;
  logic       reg_write_q, reg_write_d;
  logic       alu_src_a_q, alu_src_a_d;
  logic [1:0] alu_src_b_q, alu_src_b_d;
  logic [1:0] alu_op_q, alu_op_d;
  logic [1:0] pc_source_q, pc_source_d;

  logic       fetch_write;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      FETCH:   if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        op_d = bus.op;
        case (bus.op)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_R:             state_d = EXEC;
          OP_BEQ, OP_BNE:   state_d = BRANCH;
          OP_ADDI, OP_ANDI: state_d = IEXEC;
          OP_J:             state_d = JUMP;
          default:          state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        if (op_q == OP_LW)      state_d = MEMRD;
        else if (op_q == OP_SW) state_d = MEMWR;
        else                    state_d = FETCH;
      end
      MEMRD:   if (bus.mem_ready) state_d = MEMWB;
      MEMWR:   if (bus.mem_ready) state_d = FETCH;
      EXEC:    state_d = ALUWB;
      IEXEC:   state_d = IWB;
      MEMWB, ALUWB, IWB, BRANCH, JUMP, ILLEGAL: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are decoded for the upcoming state so they line up with state_q.
  // op_d is used because BRANCH/IEXEC are entered in the same edge op_q loads.
  always_comb begin
    pc_write_d  = 1'b0;
    branch_d    = 1'b0;
    branch_ne_d = 1'b0;
    iord_d      = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_dst_d   = 1'b0;
    memto_reg_d = 1'b0;
    reg_write_d = 1'b0;
    alu_src_a_d = 1'b0;
    alu_src_b_d = 2'b00;
    alu_op_d    = 2'b00;
    pc_source_d = 2'b00;
    case (state_d)
      FETCH: begin
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
      end
      DECODE: alu_src_b_d = 2'b11;
      MEMADR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      MEMRD: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      MEMWB: begin
        memto_reg_d = 1'b1;
        reg_write_d = 1'b1;
      end
      MEMWR: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      EXEC: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'b10;
      end
      ALUWB: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
      end
      BRANCH: begin
        alu_src_a_d = 1'b1;
        alu_op_d    = 2'b01;
        pc_source_d = 2'b01;
        branch_d    = (op_d == OP_BEQ);
        branch_ne_d = (op_d == OP_BNE);
      end
      IEXEC: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
        alu_op_d    = (op_d == OP_ANDI) ? 2'b11 : 2'b00;
      end
      IWB:  reg_write_d = 1'b1;
      JUMP: begin
        pc_write_d  = 1'b1;
        pc_source_d = 2'b10;
      end
      default: ;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == ILLEGAL);

  // Reset values of the output flops equal the FETCH decode, since reset
  // parks the machine in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      op_q        <= 6'd0;
      illegal_q   <= 1'b0;
      pc_write_q  <= 1'b0;
      branch_q    <= 1'b0;
      branch_ne_q <= 1'b0;
      iord_q      <= 1'b0;
      mem_read_q  <= 1'b1;
      mem_write_q <= 1'b0;
      reg_dst_q   <= 1'b0;
      memto_reg_q <= 1'b0;
      reg_write_q <= 1'b0;
      alu_src_a_q <= 1'b0;
      alu_src_b_q <= 2'b01;
      alu_op_q    <= 2'b00;
      pc_source_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      illegal_q   <= illegal_d;
      pc_write_q  <= pc_write_d;
      branch_q    <= branch_d;
      branch_ne_q <= branch_ne_d;
      iord_q      <= iord_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_dst_q   <= reg_dst_d;
      memto_reg_q <= memto_reg_d;
      reg_write_q <= reg_write_d;
      alu_src_a_q <= alu_src_a_d;
      alu_src_b_q <= alu_src_b_d;
      alu_op_q    <= alu_op_d;
      pc_source_q <= pc_source_d;
    end
  end

  // The fetch strobes follow mem_ready within the cycle, and are held off
  // while reset keeps the machine parked in FETCH.
  assign fetch_write = (state_q == FETCH) && bus.mem_ready && !rst;

  assign bus.PCWrite  = pc_write_q | fetch_write;
  assign bus.IRWrite  = fetch_write;
  assign bus.MemRead  = mem_read_q & ~rst;
  assign bus.Branch   = branch_q;
  assign bus.BranchNe = branch_ne_q;
  assign bus.IorD     = iord_q;
  assign bus.MemWrite = mem_write_q;
  assign bus.RegDst   = reg_dst_q;
  assign bus.MemtoReg = memto_reg_q;
  assign bus.RegWrite = reg_write_q;
  assign bus.ALUSrcA  = alu_src_a_q;
  assign bus.ALUSrcB  = alu_src_b_q;
  assign bus.ALUop    = alu_op_q;
  assign bus.PCSource = pc_source_q;
  assign bus.illegal  = illegal_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instruction streams with
// memory stalls, checked against an instruction-level step model.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst;
  int   compare_count  = 0;
  int   mismatch_count = 0;
  logic model_illegal  = 1'b0;
  logic [5:0] legal_ops [8];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_count++;
    if (got !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] opc, input logic rdy);
    @(negedge clk);
    bus.op        = opc;
    bus.mem_ready = rdy;
  endtask

  function automatic ctrl_t observed();
    ctrl_t c;
    c.pc_write  = bus.PCWrite;
    c.branch    = bus.Branch;
    c.branch_ne = bus.BranchNe;
    c.iord      = bus.IorD;
    c.mem_read  = bus.MemRead;
    c.mem_write = bus.MemWrite;
    c.ir_write  = bus.IRWrite;
    c.reg_dst   = bus.RegDst;
    c.memto_reg = bus.MemtoReg;
    c.reg_write = bus.RegWrite;
    c.alu_src_a = bus.ALUSrcA;
    c.alu_src_b = bus.ALUSrcB;
    c.alu_op    = bus.ALUop;
    c.pc_source = bus.PCSource;
    return c;
  endfunction

  function automatic logic [6:0] enables();
    return {bus.PCWrite, bus.Branch, bus.BranchNe, bus.MemRead,
            bus.MemWrite, bus.IRWrite, bus.RegWrite};
  endfunction

  // Control word each state presents, written straight from the state table.
  function automatic ctrl_t expCtrl(input int st, input logic [5:0] opc, input logic rdy);
    ctrl_t c = '0;
    case (st)
      0: begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      1: c.alu_src_b = 2'b11;
      2: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      3: begin c.mem_read = 1'b1; c.iord = 1'b1; end
      4: begin c.memto_reg = 1'b1; c.reg_write = 1'b1; end
      5: begin c.mem_write = 1'b1; c.iord = 1'b1; end
      6: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      7: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      8: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01;
        c.branch = (opc == OP_BEQ); c.branch_ne = (opc == OP_BNE);
      end
      9: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        c.alu_op = (opc == OP_ANDI) ? 2'b11 : 2'b00;
      end
      10: c.reg_write = 1'b1;
      11: begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  // Walk one instruction through its state path; FETCH, MEMRD and MEMWR
  // hold for 'stalls' cycles of mem_ready=0 before the access completes.
  // The opcode is only meaningful in DECODE, so it is scrambled elsewhere.
  task automatic runInstr(input logic [5:0] opc, input int stalls);
    int   steps[$];
    int   idx;
    int   waited;
    int   st;
    bit   waits;
    logic rdy;
    logic [5:0] drive_op;
    case (opc)
      OP_LW:            steps = '{0, 1, 2, 3, 4};
      OP_SW:            steps = '{0, 1, 2, 5};
      OP_R:             steps = '{0, 1, 6, 7};
      OP_ADDI, OP_ANDI: steps = '{0, 1, 9, 10};
      OP_BEQ, OP_BNE:   steps = '{0, 1, 8};
      OP_J:             steps = '{0, 1, 11};
      default:          steps = '{0, 1, 12};
    endcase
    idx    = 0;
    waited = 0;
    while (idx < steps.size()) begin
      st       = steps[idx];
      waits    = (st == 0) || (st == 3) || (st == 5);
      rdy      = waits ? (waited >= stalls) : 1'($urandom_range(0, 1));
      drive_op = (st == 1) ? opc : 6'($urandom);
      applyStimulus(drive_op, rdy);
      if (st == 12) model_illegal = 1'b1;
      #1;
      checkOutput("state", 32'(bus.state), 32'(st));
      checkOutput("ctrl", 32'(observed()), 32'(expCtrl(st, opc, rdy)));
      checkOutput("illegal", 32'(bus.illegal), 32'(model_illegal));
      @(posedge clk);
      if (waits && !rdy) waited++;
      else begin
        idx++;
        waited = 0;
      end
    end
  endtask

  initial begin
    legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI};
    rst           = 1'b1;
    bus.op        = 6'd0;
    bus.mem_ready = 1'b1;

    #3;
    checkOutput("reset_state", 32'(bus.state), 32'd0);
    checkOutput("reset_illegal", 32'(bus.illegal), 32'd0);
    checkOutput("reset_enables", 32'(enables()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold_state", 32'(bus.state), 32'd0);
    checkOutput("reset_hold_enables", 32'(enables()), 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ready = 1'b0;

    runInstr(OP_LW, 0);
    runInstr(OP_SW, 3);
    runInstr(OP_BEQ, 0);
    runInstr(OP_BNE, 0);
    runInstr(OP_ANDI, 1);
    runInstr(OP_ADDI, 0);
    runInstr(OP_R, 2);
    runInstr(OP_J, 0);
    runInstr(6'b111111, 0);
    runInstr(OP_LW, 0);
    runInstr(OP_BEQ, 1);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] opc;
      if ($urandom_range(0, 9) < 8) opc = legal_ops[$urandom_range(0, 7)];
      else opc = 6'($urandom);
      runInstr(opc, int'($urandom_range(0, 3)));
    end

    // Abort a load while it waits in MEMRD.
    applyStimulus(OP_LW, 1'b1);
    @(posedge clk);
    applyStimulus(OP_LW, 1'b1);
    @(posedge clk);
    applyStimulus(OP_LW, 1'b1);
    @(posedge clk);
    applyStimulus(OP_LW, 1'b0);
    #1;
    checkOutput("memrd_state", 32'(bus.state), 32'd3);
    checkOutput("illegal_sticky", 32'(bus.illegal), 32'(model_illegal));
    #2;
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    checkOutput("async_rst_state", 32'(bus.state), 32'd0);
    checkOutput("async_rst_enables", 32'(enables()), 32'd0);
    checkOutput("async_rst_illegal", 32'(bus.illegal), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_edge_state", 32'(bus.state), 32'd0);
    checkOutput("rst_edge_enables", 32'(enables()), 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.mem_ready = 1'b0;
    model_illegal = 1'b0;

    runInstr(OP_LW, 1);
    runInstr(OP_ADDI, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
